ras_circ: RTL and testbench
===========================

Name: ras_circ

Overview:
Second-generation return address stack for the IFU branch predictor. Replaces the shifting register stack with a circular buffer indexed by a top-of-stack pointer. Adds recursion compression through per-entry repeat counters, wrap-around overwrite when full, and checkpoint/restore of pointer state for misprediction recovery. Sits beside the BTB/direction predictor in ifu/bp: push on call, pop on return, restore on backend redirect.

Parameters:
DATA_WIDTH, 64, return address width
DATA_DEPTH, 8, entry count; power of two, >= 2
CNT_WIDTH, 2, per-entry repeat counter width; saturates at 2^CNT_WIDTH-1
(derived) PTR_W = $clog2(DATA_DEPTH); OCC_W = $clog2(DATA_DEPTH+1)

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset; asynchronous, active-low
bp_flush_i  in  1  clear whole stack
ras_push_i  in  1  call: push ras_data_i
ras_pop_i  in  1  return: pop top
ras_data_i  in  DATA_WIDTH  address to push
ras_restore_i  in  1  load checkpoint
ras_restore_ptr_i  in  PTR_W  checkpoint TOS pointer
ras_restore_occ_i  in  OCC_W  checkpoint occupancy
ras_data_vld_o  out  1  stack non-empty (occ != 0)
ras_data_o  out  DATA_WIDTH  top entry, mem[tos]
ras_ckpt_ptr_o  out  PTR_W  current tos, for snapshot
ras_ckpt_occ_o  out  OCC_W  current occupancy, for snapshot
ras_full_o  out  1  occ == DATA_DEPTH
ras_ovf_o  out  1  registered pulse: previous cycle's push overwrote the oldest entry

Behaviour:
- State: mem[DATA_DEPTH], cnt[DATA_DEPTH], tos (PTR_W), occ (OCC_W), ovf flop. All outputs are driven from flops only; an update becomes visible the cycle after the event.
- Reset values: mem = 0, cnt = 0, tos = DATA_DEPTH-1 (first push writes entry 0), occ = 0, ovf = 0. Resulting outputs: vld 0, data 0, full 0, ovf 0, ckpt_ptr DATA_DEPTH-1, ckpt_occ 0.
- Priority: flush > restore > push/pop.
- Flush: same as reset, applied synchronously. Dominates all other inputs in that cycle.
- Restore: tos <= restore_ptr; occ <= min(restore_occ, DATA_DEPTH); all cnt <= 0; mem untouched; ovf <= 0. Push and pop are ignored that cycle.
- Push only, compress case: occ != 0, ras_data_i == mem[tos] and cnt[tos] not saturated. Result: cnt[tos]++, tos and occ unchanged.
- Push only, normal case: tos <= tos+1 mod DATA_DEPTH; mem[tos+1] <= data; cnt[tos+1] <= 0.
  - If occ < DATA_DEPTH: occ++.
  - If full: occ stays, the oldest entry is overwritten, ovf <= 1.
- Pop only:
  - occ == 0: no state change.
  - cnt[tos] != 0: cnt[tos]--.
  - Otherwise: tos <= tos-1 mod DATA_DEPTH; occ--.
- Push and pop together (return immediately followed by a call):
  - occ != 0: mem[tos] <= data; cnt[tos] <= 0; tos and occ unchanged.
  - occ == 0: behaves as a normal push (occ becomes 1).
- ovf is 1 for exactly one cycle per overwriting push. It is 0 in every other cycle.
- Pointer arithmetic is modulo DATA_DEPTH via natural PTR_W wrap. No divider.
- Restore recovers pointer and occupancy only. Entries overwritten after the checkpoint and cleared counters are accepted prediction inaccuracy, not a functional error.
- Reset asserted mid-operation clears all state asynchronously. The first push after deassertion writes entry 0.

Decomposition:
- Shared package bp_pkg:
  - ras_ckpt_t struct {ptr, occ} sized for the default DATA_DEPTH, used by the IFU redirect queue.
  - Constants RAS_DEPTH and RAS_CNT_WIDTH.
- Saturating increment/decrement as package functions.
- No sub-module; a single flat module with one always_comb next-state block and one always_ff.

Test Plan:
- Bench uses DATA_DEPTH=4, CNT_WIDTH=2.
- Reset, then push 0x100, 0x200, 0x300 on consecutive cycles -> data_o 0x300, occ 3, ptr 2; three pops -> 0x200, 0x100, then vld 0, occ 0.
- Push 0x100..0x500 (5 pushes) -> ovf pulses 1 cycle after the 5th push only, full 1, occ 4; four pops return 0x500, 0x400, 0x300, 0x200; fifth pop leaves vld 0.
- Push 0xA0 five times -> occ 1, cnt[0] saturates at 3, fifth push allocates a new entry (occ 2); pops needed to empty = 5.
- Stack holding 0x100, 0x200: simultaneous push 0x999 + pop -> data_o 0x999, occ 2, ptr unchanged; push+pop on empty stack -> occ 1, data 0x999.
- Snapshot ptr/occ after 2 pushes, push 2 more, assert restore -> ptr/occ equal the snapshot, data_o = second pushed value; restore with push in same cycle -> push ignored.
- Flush and reset each asserted mid-sequence, and flush+restore+push together -> all outputs at reset values next cycle (ptr 3, occ 0).

Source files
------------

// File: rtl/bp_pkg.sv
// Branch-predictor shared types and helpers.
// Holds the return address stack (RAS) defaults, the checkpoint payload carried by
// the IFU redirect queue, and saturating counter helpers.
package bp_pkg;

   localparam int unsigned RAS_DEPTH     = 8;
   localparam int unsigned RAS_CNT_WIDTH = 2;
   localparam int unsigned RAS_PTR_W     = $clog2(RAS_DEPTH);
   localparam int unsigned RAS_OCC_W     = $clog2(RAS_DEPTH + 1);

   // Pointer/occupancy snapshot taken at prediction time, replayed on redirect
   typedef struct packed {
      logic [RAS_PTR_W-1:0] ptr;
      logic [RAS_OCC_W-1:0] occ;
   } ras_ckpt_t;

   // Counter helpers on an 8-bit carrier; callers zero-extend and truncate
   function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic [7:0] max_v);
      return (v >= max_v) ? v : v + 8'd1;
   endfunction

   function automatic logic [7:0] sat_dec(input logic [7:0] v);
      return (v == 8'd0) ? v : v - 8'd1;
   endfunction

endpackage

// File: rtl/ras_circ.sv
// Circular return address stack with recursion compression and checkpoint restore.
// Ports:
//   clk_i, rst_ni           clock, async active-low reset
//   bp_flush_i              synchronous clear of the whole stack
//   ras_push_i/ras_data_i   call: push return address
//   ras_pop_i               return: pop top
//   ras_restore_i/_ptr_i/_occ_i  reload pointer and occupancy from a checkpoint
//   ras_data_vld_o, ras_data_o   top-of-stack valid and value
//   ras_ckpt_ptr_o/_occ_o   current pointer/occupancy for snapshotting
//   ras_full_o, ras_ovf_o   stack full, one-cycle overwrite pulse
module ras_circ
   import bp_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned DATA_DEPTH = RAS_DEPTH,
   parameter int unsigned CNT_WIDTH  = RAS_CNT_WIDTH,
   localparam int unsigned PTR_W     = $clog2(DATA_DEPTH),
   localparam int unsigned OCC_W     = $clog2(DATA_DEPTH + 1)
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  bp_flush_i,
   input  logic                  ras_push_i,
   input  logic                  ras_pop_i,
   input  logic [DATA_WIDTH-1:0] ras_data_i,
   input  logic                  ras_restore_i,
   input  logic [PTR_W-1:0]      ras_restore_ptr_i,
   input  logic [OCC_W-1:0]      ras_restore_occ_i,
   output logic                  ras_data_vld_o,
   output logic [DATA_WIDTH-1:0] ras_data_o,
   output logic [PTR_W-1:0]      ras_ckpt_ptr_o,
   output logic [OCC_W-1:0]      ras_ckpt_occ_o,
   output logic                  ras_full_o,
   output logic                  ras_ovf_o
);

   localparam logic [PTR_W-1:0]     TOS_RST = PTR_W'(DATA_DEPTH - 1);
   localparam logic [OCC_W-1:0]     OCC_MAX = OCC_W'(DATA_DEPTH);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   logic [DATA_WIDTH-1:0] mem_q [DATA_DEPTH];
   logic [DATA_WIDTH-1:0] mem_d [DATA_DEPTH];
   logic [CNT_WIDTH-1:0]  cnt_q [DATA_DEPTH];
   logic [CNT_WIDTH-1:0]  cnt_d [DATA_DEPTH];
   logic [PTR_W-1:0]      tos_q, tos_d;
   logic [OCC_W-1:0]      occ_q, occ_d;
   logic                  ovf_q, ovf_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  vld_q, vld_d;
   logic                  full_q, full_d;

   logic [PTR_W-1:0] tos_inc, tos_dec;
   logic             empty, is_full, compress;

   assign tos_inc  = PTR_W'(tos_q + PTR_W'(1));
   assign tos_dec  = PTR_W'(tos_q - PTR_W'(1));
   assign empty    = (occ_q == '0);
   assign is_full  = (occ_q == OCC_MAX);
   // Repeated call to the same return address folds into the top entry's counter
   assign compress = !empty && (ras_data_i == mem_q[tos_q]) && (cnt_q[tos_q] != CNT_MAX);

   // Next-state: flush > restore > push/pop
   always_comb begin
      mem_d = mem_q;
      cnt_d = cnt_q;
      tos_d = tos_q;
      occ_d = occ_q;
      ovf_d = 1'b0;

      if (bp_flush_i) begin
         for (int unsigned i = 0; i < DATA_DEPTH; i++) begin
            mem_d[i] = '0;
            cnt_d[i] = '0;
         end
         tos_d = TOS_RST;
         occ_d = '0;
      end else if (ras_restore_i) begin
         for (int unsigned i = 0; i < DATA_DEPTH; i++) cnt_d[i] = '0;
         tos_d = ras_restore_ptr_i;
         occ_d = (ras_restore_occ_i > OCC_MAX) ? OCC_MAX : ras_restore_occ_i;
      end else if (ras_push_i && ras_pop_i && !empty) begin
         // Return then call: replace top in place
         mem_d[tos_q] = ras_data_i;
         cnt_d[tos_q] = '0;
      end else if (ras_push_i) begin
         if (compress) begin
            cnt_d[tos_q] = CNT_WIDTH'(sat_inc(8'(cnt_q[tos_q]), 8'(CNT_MAX)));
         end else begin
            tos_d          = tos_inc;
            mem_d[tos_inc] = ras_data_i;
            cnt_d[tos_inc] = '0;
            if (is_full) ovf_d = 1'b1;
            else         occ_d = OCC_W'(occ_q + OCC_W'(1));
         end
      end else if (ras_pop_i && !empty) begin
         if (cnt_q[tos_q] != '0) begin
            cnt_d[tos_q] = CNT_WIDTH'(sat_dec(8'(cnt_q[tos_q])));
         end else begin
            tos_d = tos_dec;
            occ_d = OCC_W'(occ_q - OCC_W'(1));
         end
      end

      data_d = mem_d[tos_d];
      vld_d  = (occ_d != '0);
      full_d = (occ_d == OCC_MAX);
   end

   // State and output registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int unsigned i = 0; i < DATA_DEPTH; i++) begin
            mem_q[i] <= '0;
            cnt_q[i] <= '0;
         end
         tos_q  <= TOS_RST;
         occ_q  <= '0;
         ovf_q  <= 1'b0;
         data_q <= '0;
         vld_q  <= 1'b0;
         full_q <= 1'b0;
      end else begin
         mem_q  <= mem_d;
         cnt_q  <= cnt_d;
         tos_q  <= tos_d;
         occ_q  <= occ_d;
         ovf_q  <= ovf_d;
         data_q <= data_d;
         vld_q  <= vld_d;
         full_q <= full_d;
      end
   end

   assign ras_data_vld_o = vld_q;
   assign ras_data_o     = data_q;
   assign ras_ckpt_ptr_o = tos_q;
   assign ras_ckpt_occ_o = occ_q;
   assign ras_full_o     = full_q;
   assign ras_ovf_o      = ovf_q;

endmodule

// File: tb/tb_ras_circ.sv
// Directed vector bench for ras_circ at DATA_DEPTH=4, CNT_WIDTH=2.
module tb_ras_circ;

   localparam int unsigned DW    = 16;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned PTR_W = 2;
   localparam int unsigned OCC_W = 3;

   logic             clk_i = 1'b0;
   logic             rst_ni = 1'b0;
   logic             bp_flush_i = 1'b0;
   logic             ras_push_i = 1'b0;
   logic             ras_pop_i = 1'b0;
   logic [DW-1:0]    ras_data_i = '0;
   logic             ras_restore_i = 1'b0;
   logic [PTR_W-1:0] ras_restore_ptr_i = '0;
   logic [OCC_W-1:0] ras_restore_occ_i = '0;
   logic             ras_data_vld_o;
   logic [DW-1:0]    ras_data_o;
   logic [PTR_W-1:0] ras_ckpt_ptr_o;
   logic [OCC_W-1:0] ras_ckpt_occ_o;
   logic             ras_full_o;
   logic             ras_ovf_o;

   ras_circ #(.DATA_WIDTH(DW), .DATA_DEPTH(DEPTH), .CNT_WIDTH(2)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .bp_flush_i(bp_flush_i),
      .ras_push_i(ras_push_i), .ras_pop_i(ras_pop_i), .ras_data_i(ras_data_i),
      .ras_restore_i(ras_restore_i), .ras_restore_ptr_i(ras_restore_ptr_i),
      .ras_restore_occ_i(ras_restore_occ_i), .ras_data_vld_o(ras_data_vld_o),
      .ras_data_o(ras_data_o), .ras_ckpt_ptr_o(ras_ckpt_ptr_o),
      .ras_ckpt_occ_o(ras_ckpt_occ_o), .ras_full_o(ras_full_o), .ras_ovf_o(ras_ovf_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic          flush, restore, push, pop;
      logic [DW-1:0] data;
      logic [1:0]    rptr;
      logic [2:0]    rocc;
      logic          e_vld;
      logic [DW-1:0] e_data;
      logic [1:0]    e_ptr;
      logic [2:0]    e_occ;
      logic          e_full, e_ovf;
   } vec_t;

   vec_t vecs[$];
   int   n_vec  = 0;
   int   n_miss = 0;

   function automatic vec_t mk(input logic fl, input logic rs, input logic pu, input logic po,
                               input logic [DW-1:0] d, input logic [1:0] rp, input logic [2:0] ro,
                               input logic ev, input logic [DW-1:0] ed, input logic [1:0] ep,
                               input logic [2:0] eo, input logic ef, input logic eov);
      vec_t v;
      v.flush = fl; v.restore = rs; v.push = pu; v.pop = po; v.data = d;
      v.rptr = rp; v.rocc = ro; v.e_vld = ev; v.e_data = ed; v.e_ptr = ep;
      v.e_occ = eo; v.e_full = ef; v.e_ovf = eov;
      return v;
   endfunction

   task automatic check(input string nm, input logic ev, input logic [DW-1:0] ed,
                        input logic [1:0] ep, input logic [2:0] eo, input logic ef, input logic eov);
      n_vec++;
      if ({ras_data_vld_o, ras_data_o, ras_ckpt_ptr_o, ras_ckpt_occ_o, ras_full_o, ras_ovf_o} !==
          {ev, ed, ep, eo, ef, eov}) begin
         n_miss++;
         $display("FAIL %s: got vld=%0b data=%h ptr=%0d occ=%0d full=%0b ovf=%0b, want vld=%0b data=%h ptr=%0d occ=%0d full=%0b ovf=%0b",
                  nm, ras_data_vld_o, ras_data_o, ras_ckpt_ptr_o, ras_ckpt_occ_o, ras_full_o, ras_ovf_o,
                  ev, ed, ep, eo, ef, eov);
      end
   endtask

   // Drive one cycle of inputs, then sample just after the capturing edge
   task automatic apply(input vec_t v);
      bp_flush_i = v.flush; ras_restore_i = v.restore; ras_push_i = v.push; ras_pop_i = v.pop;
      ras_data_i = v.data; ras_restore_ptr_i = v.rptr; ras_restore_occ_i = v.rocc;
      @(posedge clk_i);
      #1;
      bp_flush_i = 1'b0; ras_restore_i = 1'b0; ras_push_i = 1'b0; ras_pop_i = 1'b0;
   endtask

   initial begin
      // op shorthand: (flush, restore, push, pop, data, rptr, rocc) -> (vld, data, ptr, occ, full, ovf)
      // Basic LIFO
      vecs.push_back(mk(0,0,1,0,16'h100,0,0, 1,16'h100,0,1,0,0));
      vecs.push_back(mk(0,0,1,0,16'h200,0,0, 1,16'h200,1,2,0,0));
      vecs.push_back(mk(0,0,1,0,16'h300,0,0, 1,16'h300,2,3,0,0));
      vecs.push_back(mk(0,0,0,1,16'h0,  0,0, 1,16'h200,1,2,0,0));
      vecs.push_back(mk(0,0,0,1,16'h0,  0,0, 1,16'h100,0,1,0,0));
      vecs.push_back(mk(0,0,0,1,16'h0,  0,0, 0,16'h000,3,0,0,0));
      vecs.push_back(mk(0,0,0,1,16'h0,  0,0, 0,16'h000,3,0,0,0)); // pop on empty
      // Wrap-around overwrite
      vecs.push_back(mk(0,0,1,0,16'h100,0,0, 1,16'h100,0,1,0,0));
      vecs.push_back(mk(0,0,1,0,16'h200,0,0, 1,16'h200,1,2,0,0));
      vecs.push_back(mk(0,0,1,0,16'h300,0,0, 1,16'h300,2,3,0,0));
      vecs.push_back(mk(0,0,1,0,16'h400,0,0, 1,16'h400,3,4,1,0));
      vecs.push_back(mk(0,0,1,0,16'h500,0,0, 1,16'h500,0,4,1,1));
      vecs.push_back(mk(0,0,0,0,16'h0,  0,0, 1,16'h500,0,4,1,0));
      vecs.push_back(mk(0,0,0,1,16'h0,  0,0, 1,16'h400,3,3,0,0));
      vecs.push_back(mk(0,0,0,1,16'h0,  0,0, 1,16'h300,2,2,0,0));
      vecs.push_back(mk(0,0,0,1,16'h0,  0,0, 1,16'h200,1,1,0,0));
      vecs.push_back(mk(0,0,0,1,16'h0,  0,0, 0,16'h500,0,0,0,0));
      // Flush, then recursion compression to saturation
      vecs.push_back(mk(1,0,0,0,16'h0,  0,0, 0,16'h000,3,0,0,0));
      vecs.push_back(mk(0,0,1,0,16'hA0, 0,0, 1,16'h0A0,0,1,0,0));
      vecs.push_back(mk(0,0,1,0,16'hA0, 0,0, 1,16'h0A0,0,1,0,0));
      vecs.push_back(mk(0,0,1,0,16'hA0, 0,0, 1,16'h0A0,0,1,0,0));
      vecs.push_back(mk(0,0,1,0,16'hA0, 0,0, 1,16'h0A0,0,1,0,0));
      vecs.push_back(mk(0,0,1,0,16'hA0, 0,0, 1,16'h0A0,1,2,0,0));
      vecs.push_back(mk(0,0,0,1,16'h0,  0,0, 1,16'h0A0,0,1,0,0));
      vecs.push_back(mk(0,0,0,1,16'h0,  0,0, 1,16'h0A0,0,1,0,0));
      vecs.push_back(mk(0,0,0,1,16'h0,  0,0, 1,16'h0A0,0,1,0,0));
      vecs.push_back(mk(0,0,0,1,16'h0,  0,0, 1,16'h0A0,0,1,0,0));
      vecs.push_back(mk(0,0,0,1,16'h0,  0,0, 0,16'h000,3,0,0,0));
      // Simultaneous push+pop
      vecs.push_back(mk(0,0,1,0,16'h100,0,0, 1,16'h100,0,1,0,0));
      vecs.push_back(mk(0,0,1,0,16'h200,0,0, 1,16'h200,1,2,0,0));
      vecs.push_back(mk(0,0,1,1,16'h999,0,0, 1,16'h999,1,2,0,0));
      vecs.push_back(mk(0,0,0,1,16'h0,  0,0, 1,16'h100,0,1,0,0));
      vecs.push_back(mk(0,0,0,1,16'h0,  0,0, 0,16'h000,3,0,0,0));
      vecs.push_back(mk(0,0,1,1,16'h999,0,0, 1,16'h999,0,1,0,0));
      // Mid-sequence flush, checkpoint restore
      vecs.push_back(mk(1,0,0,0,16'h0,  0,0, 0,16'h000,3,0,0,0));
      vecs.push_back(mk(0,0,1,0,16'h111,0,0, 1,16'h111,0,1,0,0));
      vecs.push_back(mk(0,0,1,0,16'h222,0,0, 1,16'h222,1,2,0,0));
      vecs.push_back(mk(0,0,1,0,16'h333,0,0, 1,16'h333,2,3,0,0));
      vecs.push_back(mk(0,0,1,0,16'h444,0,0, 1,16'h444,3,4,1,0));
      vecs.push_back(mk(0,1,0,0,16'h0,  1,2, 1,16'h222,1,2,0,0));
      vecs.push_back(mk(0,1,1,0,16'h555,3,7, 1,16'h444,3,4,1,0)); // push ignored, occ clamped
      vecs.push_back(mk(0,0,0,1,16'h0,  0,0, 1,16'h333,2,3,0,0));
      // Flush dominates restore and push
      vecs.push_back(mk(1,1,1,0,16'h777,1,2, 0,16'h000,3,0,0,0));
      vecs.push_back(mk(0,0,1,0,16'h0AA,0,0, 1,16'h0AA,0,1,0,0));

      rst_ni = 1'b0;
      repeat (2) @(posedge clk_i);
      #1;
      check("reset", 0, 16'h0, 2'd3, 3'd0, 0, 0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      @(posedge clk_i);
      #1;

      for (int i = 0; i < vecs.size(); i++) begin
         apply(vecs[i]);
         check($sformatf("vec%0d", i), vecs[i].e_vld, vecs[i].e_data, vecs[i].e_ptr,
               vecs[i].e_occ, vecs[i].e_full, vecs[i].e_ovf);
      end

      // Asynchronous reset mid-operation, with a push still pending
      apply(mk(0,0,1,0,16'h123,0,0, 0,0,0,0,0,0));
      ras_push_i = 1'b1; ras_data_i = 16'h456;
      #2;
      rst_ni = 1'b0;
      #1;
      check("async_rst", 0, 16'h0, 2'd3, 3'd0, 0, 0);
      ras_push_i = 1'b0;
      @(negedge clk_i);
      rst_ni = 1'b1;
      @(posedge clk_i);
      #1;
      check("post_rst_idle", 0, 16'h0, 2'd3, 3'd0, 0, 0);
      apply(mk(0,0,1,0,16'hBEE,0,0, 0,0,0,0,0,0));
      check("post_rst_push", 1, 16'hBEE, 2'd0, 3'd1, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
